// File: rtl/xalu_alzette_seq.sv
// Multi-cycle Alzette ARX-box for the Sparkle ISE: x returned on completion,
// y held in ybuf for a following single-cycle read. SPC must be 1, 2 or 4.
module xalu_alzette_seq #(
  parameter int SPC   = 1,
  parameter bit DEC_E = 1'b0
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic [5:0]  ise_fn,
  input  logic [6:0]  ise_imm,
  input  logic [31:0] ise_in1,
  input  logic [31:0] ise_in2,
  input  logic        ise_val,
  output logic        ise_oval,
  output logic [31:0] ise_out,
  output logic        ise_busy
);

  // state | meaning
  // IDLE  | waiting; serves y reads combinationally
  // RUN   | SPC Alzette steps applied per cycle
  // DONE  | one-cycle x result pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, y_q, c_q, xres_q, ybuf_q;
  logic        dec_q;
  logic [2:0]  cnt_q;
  logic [31:0] x_n, y_n;
  logic [1:0]  step_k, step_i;
  logic        start, last;
  logic        unused_fn;

  wire [3:0] op     = ise_imm[6:3];
  wire       sel    = (ise_fn[1:0] == 2'b10) && ise_val;
  wire       is_x   = (op == 4'b1100) || (DEC_E && op == 4'b1110);
  wire       is_y   = (op == 4'b1101) || (DEC_E && op == 4'b1111);

  assign unused_fn = ^ise_fn[5:2];

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] t;
    t = {v, v} >> r;
    return t[31:0];
  endfunction

  function automatic logic [4:0] rot_r(input logic [1:0] i);
    case (i)
      2'd0:    return 5'd31;
      2'd1:    return 5'd17;
      2'd2:    return 5'd0;
      default: return 5'd24;
    endcase
  endfunction

  function automatic logic [4:0] rot_s(input logic [1:0] i);
    case (i)
      2'd0:    return 5'd24;
      2'd1:    return 5'd17;
      2'd2:    return 5'd31;
      default: return 5'd16;
    endcase
  endfunction

  function automatic logic [31:0] rcon(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'hB7E15162;
      3'd1:    return 32'hBF715880;
      3'd2:    return 32'h38B4DA56;
      3'd3:    return 32'h324E7738;
      3'd4:    return 32'hBB1185EB;
      3'd5:    return 32'h4F7C7B57;
      3'd6:    return 32'hCFBFA1C8;
      default: return 32'hC2B3293D;
    endcase
  endfunction

  // Unrolled chain of SPC steps starting at the current step count;
  // decryption walks the step schedule backwards.
  always_comb begin
    x_n    = x_q;
    y_n    = y_q;
    step_k = 2'd0;
    step_i = 2'd0;
    for (int j = 0; j < SPC; j++) begin
      step_k = cnt_q[1:0] + 2'(j);
      if (dec_q) begin
        step_i = 2'd3 - step_k;
        x_n = x_n ^ c_q;
        y_n = y_n ^ ror32(x_n, rot_s(step_i));
        x_n = x_n - ror32(y_n, rot_r(step_i));
      end else begin
        step_i = step_k;
        x_n = x_n + ror32(y_n, rot_r(step_i));
        y_n = y_n ^ ror32(x_n, rot_s(step_i));
        x_n = x_n ^ c_q;
      end
    end
  end

  assign last = (cnt_q + 3'(SPC)) == 3'd4;

  always_ff @(posedge ise_clk) begin
    if (ise_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    ise_oval = 1'b0;
    ise_out  = 32'h0;
    ise_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel && is_x) begin
          start   = 1'b1;
          state_d = S_RUN;
        end else if (sel && is_y) begin
          ise_oval = 1'b1;
          ise_out  = ybuf_q;
        end
      end
      S_RUN: begin
        ise_busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        ise_busy = 1'b1;
        ise_oval = 1'b1;
        ise_out  = xres_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset wins over any request presented in the same cycle.
    if (ise_rst) begin
      start    = 1'b0;
      ise_oval = 1'b0;
      ise_out  = 32'h0;
      ise_busy = 1'b0;
    end
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      x_q    <= 32'h0;
      y_q    <= 32'h0;
      c_q    <= 32'h0;
      dec_q  <= 1'b0;
      cnt_q  <= 3'd0;
      xres_q <= 32'h0;
      ybuf_q <= 32'h0;
    end else if (start) begin
      x_q   <= ise_in1;
      y_q   <= ise_in2;
      c_q   <= rcon(ise_imm[2:0]);
      dec_q <= op[1];
      cnt_q <= 3'd0;
    end else if (state_q == S_RUN) begin
      if (last) begin
        xres_q <= x_n;
        ybuf_q <= y_n;
        cnt_q  <= 3'd0;
      end else begin
        x_q   <= x_n;
        y_q   <= y_n;
        cnt_q <= cnt_q + 3'(SPC);
      end
    end
  end

endmodule

// File: tb/tb_xalu_alzette_seq.sv
// Bench for xalu_alzette_seq: four instances (SPC 1/2/4 with decrypt, SPC 1 without)
// share stimulus and are checked against a plain Alzette model and latency table.
module tb_xalu_alzette_seq;

  logic        ise_clk = 1'b0;
  logic        ise_rst = 1'b1;
  logic [5:0]  ise_fn  = 6'h0;
  logic [6:0]  ise_imm = 7'h0;
  logic [31:0] ise_in1 = 32'h0;
  logic [31:0] ise_in2 = 32'h0;
  logic        ise_val = 1'b0;
  logic [3:0]  oval;
  logic [3:0]  busy;
  logic [31:0] dout [4];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ymod     [4];
  logic [31:0] last_out [4];
  int          lat      [4] = '{5, 3, 2, 5};
  bit          dec_en   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] consts   [8] = '{32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
                                32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D};
  int          rr [4] = '{31, 17, 0, 24};
  int          ss [4] = '{24, 17, 31, 16};

  always #5 ise_clk = ~ise_clk;

  xalu_alzette_seq #(.SPC(1), .DEC_E(1'b1)) u0 (.ise_clk(ise_clk), .ise_rst(ise_rst), .ise_fn(ise_fn),
    .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
    .ise_oval(oval[0]), .ise_out(dout[0]), .ise_busy(busy[0]));
  xalu_alzette_seq #(.SPC(2), .DEC_E(1'b1)) u1 (.ise_clk(ise_clk), .ise_rst(ise_rst), .ise_fn(ise_fn),
    .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
    .ise_oval(oval[1]), .ise_out(dout[1]), .ise_busy(busy[1]));
  xalu_alzette_seq #(.SPC(4), .DEC_E(1'b1)) u2 (.ise_clk(ise_clk), .ise_rst(ise_rst), .ise_fn(ise_fn),
    .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
    .ise_oval(oval[2]), .ise_out(dout[2]), .ise_busy(busy[2]));
  xalu_alzette_seq #(.SPC(1), .DEC_E(1'b0)) u3 (.ise_clk(ise_clk), .ise_rst(ise_rst), .ise_fn(ise_fn),
    .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2), .ise_val(ise_val),
    .ise_oval(oval[3]), .ise_out(dout[3]), .ise_busy(busy[3]));

  function automatic logic [31:0] rotr(input logic [31:0] v, input int r);
    if (r == 0) return v;
    return (v >> r) | (v << (32 - r));
  endfunction

  function automatic logic [63:0] alz_enc(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    for (int i = 0; i < 4; i++) begin
      x = x + rotr(y, rr[i]);
      y = y ^ rotr(x, ss[i]);
      x = x ^ c;
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] alz_dec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] c);
    for (int i = 3; i >= 0; i--) begin
      x = x ^ c;
      y = y ^ rotr(x, ss[i]);
      x = x - rotr(y, rr[i]);
    end
    return {x, y};
  endfunction

  task automatic next_cycle();
    @(posedge ise_clk);
    #1;
  endtask

  // Start an x op in cycle 0, drop val and scramble operands in cycle 1,
  // then check oval/busy/out of every instance through cycle 6.
  task automatic run_x(input logic [3:0] op, input logic [2:0] idx, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] res;
    bit          en [4];
    bit          eo, eb;
    logic [31:0] eout;
    res = (op == 4'b1100) ? alz_enc(x, y, consts[idx]) : alz_dec(x, y, consts[idx]);
    for (int k = 0; k < 4; k++)
      en[k] = (op == 4'b1100) || (op == 4'b1110 && dec_en[k]);
    next_cycle();
    ise_fn  = {4'($urandom), 2'b10};
    ise_imm = {op, idx};
    ise_in1 = x;
    ise_in2 = y;
    ise_val = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_cycle();
      if (c == 1) begin
        ise_val = 1'b0;
        ise_in1 = $urandom;
        ise_in2 = $urandom;
      end
      @(negedge ise_clk);
      for (int k = 0; k < 4; k++) begin
        eo   = en[k] && (c == lat[k]);
        eb   = en[k] && (c >= 1) && (c <= lat[k]);
        eout = eo ? res[63:32] : 32'h0;
        checks++;
        if (oval[k] !== eo || busy[k] !== eb || dout[k] !== eout) begin
          failures++;
          $display("FAIL run_x dut%0d op=%b cyc=%0d: oval=%b busy=%b out=%h, required oval=%b busy=%b out=%h",
                   k, op, c, oval[k], busy[k], dout[k], eo, eb, eout);
        end
        if (eo) last_out[k] = dout[k];
      end
    end
    for (int k = 0; k < 4; k++)
      if (en[k]) ymod[k] = res[31:0];
  endtask

  task automatic read_y(input logic [3:0] op);
    bit          en;
    logic [31:0] eout;
    next_cycle();
    ise_fn  = {4'($urandom), 2'b10};
    ise_imm = {op, 3'($urandom)};
    ise_val = 1'b1;
    @(negedge ise_clk);
    for (int k = 0; k < 4; k++) begin
      en   = (op == 4'b1101) || (op == 4'b1111 && dec_en[k]);
      eout = en ? ymod[k] : 32'h0;
      checks++;
      if (oval[k] !== en || busy[k] !== 1'b0 || dout[k] !== eout) begin
        failures++;
        $display("FAIL read_y dut%0d op=%b: oval=%b busy=%b out=%h, required oval=%b busy=0 out=%h",
                 k, op, oval[k], busy[k], dout[k], en, eout);
      end
      if (en) last_out[k] = dout[k];
    end
    next_cycle();
    ise_val = 1'b0;
  endtask

  task automatic test_reset();
    ise_rst = 1'b1;
    ise_fn  = 6'b000010;
    ise_imm = 7'b1101_000;
    ise_val = 1'b1;
    repeat (2) next_cycle();
    @(negedge ise_clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oval[k] !== 1'b0 || busy[k] !== 1'b0 || dout[k] !== 32'h0) begin
        failures++;
        $display("FAIL reset dut%0d: oval=%b busy=%b out=%h, required all 0", k, oval[k], busy[k], dout[k]);
      end
      ymod[k] = 32'h0;
    end
    next_cycle();
    ise_rst = 1'b0;
    ise_val = 1'b0;
    read_y(4'b1101);
  endtask

  task automatic test_zero();
    run_x(4'b1100, 3'd0, 32'h0, 32'h0);
    read_y(4'b1101);
  endtask

  task automatic test_sweep();
    for (int idx = 0; idx < 8; idx++) begin
      for (int n = 0; n < 120; n++) begin
        run_x(($urandom_range(0, 3) == 0) ? 4'b1110 : 4'b1100, 3'(idx), $urandom, $urandom);
        read_y(($urandom_range(0, 1) == 0) ? 4'b1101 : 4'b1111);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [31:0] ex, ey;
    logic [63:0] m;
    m  = alz_enc(32'h01234567, 32'h89ABCDEF, consts[5]);
    ex = m[63:32];
    ey = m[31:0];
    run_x(4'b1100, 3'd5, 32'h01234567, 32'h89ABCDEF);
    read_y(4'b1101);
    run_x(4'b1110, 3'd5, ex, ey);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (last_out[k] !== 32'h01234567) begin
        failures++;
        $display("FAIL roundtrip_x dut%0d: got %h, required 01234567", k, last_out[k]);
      end
    end
    read_y(4'b1111);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (last_out[k] !== 32'h89ABCDEF) begin
        failures++;
        $display("FAIL roundtrip_y dut%0d: got %h, required 89abcdef", k, last_out[k]);
      end
    end
  endtask

  task automatic test_ignored();
    next_cycle();
    ise_val = 1'b1;
    ise_in1 = $urandom;
    ise_in2 = $urandom;
    for (int c = 0; c < 20; c++) begin
      if (c < 10) begin
        ise_fn  = {4'($urandom), 2'($urandom_range(0, 1)) | 2'b01};
        ise_imm = {4'b1100, 3'($urandom)};
      end else begin
        ise_fn  = {4'($urandom), 2'b10};
        ise_imm = {4'($urandom_range(0, 11)), 3'($urandom)};
      end
      @(negedge ise_clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (oval[k] !== 1'b0 || busy[k] !== 1'b0 || dout[k] !== 32'h0) begin
          failures++;
          $display("FAIL ignored dut%0d cyc=%0d: oval=%b busy=%b out=%h, required all 0",
                   k, c, oval[k], busy[k], dout[k]);
        end
      end
      next_cycle();
    end
    ise_val = 1'b0;
    read_y(4'b1101);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    ise_fn  = 6'b000010;
    ise_imm = {4'b1100, 3'd3};
    ise_in1 = $urandom;
    ise_in2 = $urandom;
    ise_val = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      ise_val = 1'b0;
      ise_rst = (c == 2);
      @(negedge ise_clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (oval[k] !== 1'b0 || busy[k] !== (c == 1) || dout[k] !== 32'h0) begin
          failures++;
          $display("FAIL reset_mid dut%0d cyc=%0d: oval=%b busy=%b out=%h, required oval=0 busy=%b out=0",
                   k, c, oval[k], busy[k], dout[k], (c == 1));
        end
      end
    end
    ise_rst = 1'b0;
    for (int k = 0; k < 4; k++) ymod[k] = 32'h0;
    read_y(4'b1101);
    run_x(4'b1100, 3'd7, $urandom, $urandom);
    read_y(4'b1101);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 20; n++)
      run_x(4'b1100, 3'($urandom), $urandom, $urandom);
    read_y(4'b1101);
    read_y(4'b1101);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_roundtrip();
    test_ignored();
    test_sweep();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xalu_alzette_seq.md
Name: xalu_alzette_seq

Overview:
- Multi-cycle Alzette ARX-box unit for the RV32 Sparkle ISE datapath. It executes a full 4-step Alzette (encrypt, and optionally decrypt) on an (x, y) pair with one of eight Sparkle round constants.
- The x half is returned on completion. The y half is buffered for a following single-cycle read instruction.
- Steps per cycle are parametrised, trading area against latency. The unit sits beside the combinational xalu ISE units on the same ise_* handshake.

Parameters:
- SPC, 1, Alzette steps evaluated per clock; legal values 1, 2, 4. Compute latency is 4/SPC cycles.
- DEC_E, 1'b0, enables the inverse-Alzette opcodes (dec_x, dec_y).

Ports:
- ise_clk   input   1   clock; all state updates on rising edge.
- ise_rst   input   1   synchronous, active-high reset.
- ise_fn    input   6   opcode class; [1:0] == 2'b10 (CUSTOM_2) selects this unit.
- ise_imm   input   7   funct7: [6:3] operation, [2:0] constant index.
- ise_in1   input   32  rs1 = x input.
- ise_in2   input   32  rs2 = y input.
- ise_val   input   1   request valid; held high by the core until ise_oval.
- ise_oval  output  1   result valid, one-cycle pulse.
- ise_out   output  32  result; 0 whenever ise_oval = 0.
- ise_busy  output  1   high in RUN and DONE.

Behaviour:
- Decode (only when ise_fn[1:0] == 2'b10):
  - funct[6:3] = 1100 enc_x; 1101 enc_y.
  - 1110 dec_x; 1111 dec_y (only when DEC_E = 1, otherwise ignored).
  - Any other opcode is ignored: no oval, no state change.
- Constants by imm[2:0], 0..7: B7E15162, BF715880, 38B4DA56, 324E7738, BB1185EB, 4F7C7B57, CFBFA1C8, C2B3293D.
- Encrypt step i uses (r, s) = (31,24), (17,17), (0,31), (24,16):
  - x = x + ror(y, r)
  - y = y ^ ror(x, s)
  - x = x ^ c
- Decrypt runs the steps in reverse order, i = 3..0:
  - x = x ^ c
  - y = y ^ ror(x, s)
  - x = x - ror(y, r)
- Arithmetic is mod 2^32; ror(v, 0) = v.
- FSM states IDLE, RUN, DONE; state resets to IDLE.
- IDLE:
  - enc_x/dec_x with ise_val: latch x, y, c and direction; step counter = 0; go to RUN.
  - enc_y/dec_y with ise_val: combinational ise_oval = 1 and ise_out = ybuf in the same cycle; stay IDLE. ybuf is returned whichever direction wrote it; repeated reads are allowed.
- RUN:
  - Apply SPC consecutive steps per cycle; counter += SPC.
  - When the counter reaches 4, register the results (xres, ybuf) and go to DONE.
- DONE:
  - ise_oval = 1, ise_out = xres; go to IDLE.
  - A new start is not accepted in DONE. The core drops ise_val the cycle after oval.
- Latency: start sampled in cycle 0, ise_oval in cycle 1 + 4/SPC (SPC=1: 5, SPC=2: 3, SPC=4: 2).
- ise_val or opcode changing during RUN is ignored; operands are already latched.
- ise_val deasserted mid-RUN: the operation still completes, and oval pulses regardless.
- Reset:
  - ise_oval = 0, ise_out = 0, ise_busy = 0, ybuf = 0, xres = 0, counter = 0.
  - Reset in RUN or DONE aborts the operation with no oval; ybuf is cleared.
- Reset dominates ise_val in the same cycle.
- y read before any x op returns 0.
- ybuf is updated only in the RUN→DONE transition.

Test Plan:
- Reset, then enc_y (fn=2'b10, imm=7'b1101_000) -> ise_oval = 1 the same cycle, ise_out = 32'h0.
- enc_x, x=32'h0, y=32'h0, imm[2:0]=0, SPC=1 -> ise_busy high for cycles 1..5, ise_oval exactly in cycle 5. ise_out equals the team C alzette() model x. The following enc_y returns the model y.
- Sweep all constant indices and SPC ∈ {1,2,4} with random x, y (1000 vectors each) -> results match the C model; oval in cycle 5/3/2 respectively.
- DEC_E=1: enc_x then enc_y on (32'h01234567, 32'h89ABCDEF, idx 5); feed the outputs to dec_x/dec_y -> returns exactly 32'h01234567 and 32'h89ABCDEF.
- DEC_E=0: dec_x opcode with ise_val held 10 cycles -> ise_oval stays 0, ise_busy stays 0, ybuf unchanged. Non-CUSTOM_2 ise_fn is likewise ignored.
- Assert ise_rst in cycle 2 of an SPC=1 enc_x -> no oval, FSM returns to IDLE. The next enc_y returns 0, and a fresh enc_x completes with correct latency.
